// File: rtl/mem_write_checker_if.sv
// Core data-memory write port tap: store strobe, address, data and PC.
// The core side drives it; the checker only observes it.
interface mem_write_checker_if #(
  parameter int WIDTH = 32
);
  logic             MemWrite;
  logic [WIDTH-1:0] DataAdr;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] PC;

  modport master (output MemWrite, DataAdr, WriteData, PC);
  modport slave  (input  MemWrite, DataAdr, WriteData, PC);
endinterface

// File: rtl/mem_write_checker.sv
// Self-checking store monitor: compares qualifying core stores, in order, against
// a preloaded (address, data) table and reports a registered pass/fail verdict.
module mem_write_checker #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 1024,
  parameter int PC_MIN_WORD = 0,
  parameter int STRICT      = 1,
  localparam int IW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH + 1),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_adr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [NW-1:0]    num_exp,
  input  logic             start,
  mem_write_checker_if.slave store,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [NW-1:0]    match_cnt,
  output logic [CW-1:0]    cycle_cnt,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t           state;
  logic [NW-1:0]    num_lat;
  // Table sized to the full index range so any load_idx / match_cnt stays in bounds.
  logic [WIDTH-1:0] tbl_adr [2**IW];
  logic [WIDTH-1:0] tbl_dat [2**IW];

  logic          qual, hit, last, miss_fail, tmo;
  logic [NW-1:0] match_nxt;

  assign qual      = store.MemWrite && ((store.PC >> 2) >= WIDTH'(PC_MIN_WORD));
  assign hit       = qual && (store.DataAdr   == tbl_adr[match_cnt[IW-1:0]])
                          && (store.WriteData == tbl_dat[match_cnt[IW-1:0]]);
  assign match_nxt = match_cnt + NW'(1);
  assign last      = hit && (match_nxt == num_lat);
  assign miss_fail = qual && !hit && (STRICT != 0);
  assign tmo       = (cycle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      num_lat   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= 2'd0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
      for (int i = 0; i < 2**IW; i++) begin
        tbl_adr[i] <= '0;
        tbl_dat[i] <= '0;
      end
    end else begin
      if (state == IDLE && load_en) begin
        tbl_adr[load_idx] <= load_adr;
        tbl_dat[load_idx] <= load_data;
      end
      if (start && state != RUN) begin
        num_lat   <= num_exp;
        match_cnt <= '0;
        cycle_cnt <= '0;
        fail_code <= 2'd0;
        fail_adr  <= '0;
        fail_data <= '0;
        if (num_exp == '0) begin
          state <= PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else begin
          state <= RUN;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      end else if (state == RUN) begin
        if (cycle_cnt != CW'(TIMEOUT)) cycle_cnt <= cycle_cnt + CW'(1);
        if (hit) match_cnt <= match_nxt;
        // Final match beats mismatch beats timeout when they share a cycle.
        if (last) begin
          state <= PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (miss_fail) begin
          state     <= FAIL;
          done      <= 1'b1;
          fail_code <= 2'd1;
          fail_adr  <= store.DataAdr;
          fail_data <= store.WriteData;
        end else if (tmo) begin
          state     <= FAIL;
          done      <= 1'b1;
          fail_code <= 2'd2;
        end
      end
    end
  end

endmodule
